mips_cache_coalescing_wbuf: RTL and testbench

Parametrised, coalescing write buffer between the data cache and the Avalon-MM memory master. Cache stores are queued in a circular FIFO and drained one at a time to the bus. A store to an address that already has a pending, not-yet-presented entry is merged into that entry byte-wise instead of taking a new slot. A combinational probe port lets the read-miss path see pending write data before it fetches from memory.

---
 rtl/mips_cache_pkg.sv | 39 +++
 rtl/mips_wbuf_match.sv | 39 +++
 rtl/mips_cache_coalescing_wbuf.sv | 179 +++++++++++++++++
 tb/tb_mips_cache_coalescing_wbuf.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cache_pkg.sv
// Shared types and helpers for the data-cache coalescing write buffer.
package mips_cache_pkg;

  localparam int WB_AW     = 32;
  localparam int WB_DW     = 32;
  localparam int WB_BW     = WB_DW / 8;
  // merge_bytes works at this width so any DW up to 512 can reuse it
  localparam int WB_MAX_DW = 512;
  localparam int WB_MAX_BW = WB_MAX_DW / 8;

  typedef struct packed {
    logic             valid;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
    logic [WB_BW-1:0] be;
  } wbuf_entry_t;

  // Drain-side sequencing; only WB_STALLED changes behaviour (busy)
  typedef enum logic [1:0] {
    WB_IDLE    = 2'd0,
    WB_PRESENT = 2'd1,
    WB_STALLED = 2'd2
  } wb_state_e;

  // Byte-wise overlay of new_data onto old_data on the lanes selected by be
  function automatic logic [WB_MAX_DW-1:0] merge_bytes(
    input logic [WB_MAX_DW-1:0] old_data,
    input logic [WB_MAX_DW-1:0] new_data,
    input logic [WB_MAX_BW-1:0] be
  );
    logic [WB_MAX_DW-1:0] v_res;
    v_res = old_data;
    for (int b = 0; b < WB_MAX_BW; b++) begin
      if (be[b]) v_res[b*8 +: 8] = new_data[b*8 +: 8];
    end
    return v_res;
  endfunction

endpackage

// File: rtl/mips_wbuf_match.sv
// Address comparator across all write-buffer entries. Produces a match
// vector and the index of the youngest match, walking from head_ptr.
module mips_wbuf_match
  import mips_cache_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 32
) (
  input  logic [$clog2(DEPTH)-1:0] i_head_ptr,
  input  logic [DEPTH-1:0]         i_valid,
  input  logic [DEPTH-1:0]         i_mask,
  input  logic [AW-1:0]            i_addr_tab [DEPTH],
  input  logic [AW-1:0]            i_addr,
  output logic [DEPTH-1:0]         o_match,
  output logic [$clog2(DEPTH)-1:0] o_idx
);

  localparam int PW = $clog2(DEPTH);

  // Per-entry compare; masked entries (the locked head) never match
  always_comb begin
    o_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_match[i] = i_valid[i] && !i_mask[i] && (i_addr_tab[i] == i_addr);
    end
  end

  // Walk oldest to youngest; the last hit seen is the youngest
  always_comb begin
    logic [PW-1:0] v_pos;
    o_idx = i_head_ptr;
    v_pos = i_head_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      v_pos = i_head_ptr + PW'(k);
      if (o_match[v_pos]) o_idx = v_pos;
    end
  end

endmodule

// File: rtl/mips_cache_coalescing_wbuf.sv
// Coalescing write buffer between the data cache and the Avalon-MM master.
// Stores queue in a circular FIFO and drain one beat at a time; a store to
// an address already pending (and not on the bus) merges byte-wise.
//
// Drain FSM
//   state      | meaning
//   WB_IDLE    | no beat presented last cycle
//   WB_PRESENT | a beat was presented and accepted last cycle
//   WB_STALLED | a beat is held on the bus by waitrequest (busy)
module mips_cache_coalescing_wbuf
  import mips_cache_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic [DW/8-1:0]          in_byteenable,
  output logic                     in_ready,
  input  logic                     active,
  input  logic                     avm_waitrequest,
  output logic                     avm_write,
  output logic [AW-1:0]            avm_address,
  output logic [DW-1:0]            avm_writedata,
  output logic [DW/8-1:0]          avm_byteenable,
  input  logic [AW-1:0]            probe_addr,
  output logic                     probe_hit,
  output logic [DW-1:0]            probe_data,
  output logic [DW/8-1:0]          probe_byteenable,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = DW / 8;

  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [BW-1:0]    r_be   [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  wb_state_e        r_state;
  wb_state_e        w_state_nxt;

  logic             w_empty;
  logic             w_full;
  logic             w_busy;
  logic             w_avm_write;
  logic [DEPTH-1:0] w_lock_mask;
  logic [DEPTH-1:0] w_in_match;
  logic [PW-1:0]    w_in_idx;
  logic             w_in_hit;
  logic [DEPTH-1:0] w_pr_match;
  logic [PW-1:0]    w_pr_idx;
  logic             w_accept;
  logic             w_merge;
  logic             w_alloc;
  logic             w_retire;
  logic [DW-1:0]    w_merged;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // The head is locked while it is on the bus; it must not be merged into
  assign w_lock_mask = w_avm_write ? (DEPTH'(1) << r_head) : '0;

  mips_wbuf_match #(.DEPTH(DEPTH), .AW(AW)) u_in_match (
    .i_head_ptr (r_head),
    .i_valid    (r_valid),
    .i_mask     (w_lock_mask),
    .i_addr_tab (r_addr),
    .i_addr     (in_addr),
    .o_match    (w_in_match),
    .o_idx      (w_in_idx)
  );

  mips_wbuf_match #(.DEPTH(DEPTH), .AW(AW)) u_probe_match (
    .i_head_ptr (r_head),
    .i_valid    (r_valid),
    .i_mask     ('0),
    .i_addr_tab (r_addr),
    .i_addr     (probe_addr),
    .o_match    (w_pr_match),
    .o_idx      (w_pr_idx)
  );

  assign w_in_hit = |w_in_match;
  assign in_ready = !w_full || w_in_hit;
  assign w_accept = in_valid && in_ready;
  assign w_merge  = w_accept && w_in_hit;
  assign w_alloc  = w_accept && !w_in_hit;
  assign w_retire = w_avm_write && !avm_waitrequest;

  assign w_merged = DW'(merge_bytes(WB_MAX_DW'(r_data[w_in_idx]),
                                    WB_MAX_DW'(in_data),
                                    WB_MAX_BW'(in_byteenable)));

  // Drain FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= WB_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Drain FSM next state: stall holds the beat, otherwise track whether one went out
  always_comb begin
    w_state_nxt = WB_IDLE;
    if (w_avm_write && avm_waitrequest) w_state_nxt = WB_STALLED;
    else if (w_avm_write)               w_state_nxt = WB_PRESENT;
  end

  // Drain FSM outputs: a stalled beat stays up even if active drops
  always_comb begin
    w_busy      = (r_state == WB_STALLED);
    w_avm_write = !w_empty && (active || w_busy);
  end

  // Entry storage: retire clears head, allocate fills tail, merge overlays bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_be[i]   <= '0;
      end
    end else begin
      if (w_retire) r_valid[r_head] <= 1'b0;
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= in_addr;
        r_data[r_tail]  <= in_data;
        r_be[r_tail]    <= in_byteenable;
      end
      if (w_merge) begin
        r_data[w_in_idx] <= w_merged;
        r_be[w_in_idx]   <= r_be[w_in_idx] | in_byteenable;
      end
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc)  r_tail <= r_tail + PW'(1);
      if (w_retire) r_head <= r_head + PW'(1);
      case ({w_alloc, w_retire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign avm_write      = w_avm_write;
  assign avm_address    = w_avm_write ? r_addr[r_head] : '0;
  assign avm_writedata  = w_avm_write ? r_data[r_head] : '0;
  assign avm_byteenable = w_avm_write ? r_be[r_head]   : '0;

  assign probe_hit        = |w_pr_match;
  assign probe_data       = probe_hit ? r_data[w_pr_idx] : '0;
  assign probe_byteenable = probe_hit ? r_be[w_pr_idx]   : '0;

  assign count = r_count;
  assign full  = w_full;
  assign empty = w_empty;

endmodule

// File: tb/tb_mips_cache_coalescing_wbuf.sv
// Directed bench for the coalescing write buffer (DEPTH=8, AW=DW=32).
module tb_mips_cache_coalescing_wbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [3:0]  in_byteenable;
  logic        in_ready;
  logic        active;
  logic        avm_waitrequest;
  logic        avm_write;
  logic [31:0] avm_address;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] probe_addr;
  logic        probe_hit;
  logic [31:0] probe_data;
  logic [3:0]  probe_byteenable;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  always #5 clk = ~clk;

  mips_cache_coalescing_wbuf #(.DEPTH(8), .AW(32), .DW(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_addr          (in_addr),
    .in_data          (in_data),
    .in_byteenable    (in_byteenable),
    .in_ready         (in_ready),
    .active           (active),
    .avm_waitrequest  (avm_waitrequest),
    .avm_write        (avm_write),
    .avm_address      (avm_address),
    .avm_writedata    (avm_writedata),
    .avm_byteenable   (avm_byteenable),
    .probe_addr       (probe_addr),
    .probe_hit        (probe_hit),
    .probe_data       (probe_data),
    .probe_byteenable (probe_byteenable),
    .count            (count),
    .full             (full),
    .empty            (empty)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  logic [31:0] got_addr[$], got_data[$], exp_addr[$], exp_data[$];
  logic [3:0]  got_be[$], exp_be[$];

  // Bus monitor: capture every accepted beat
  always @(posedge clk) begin
    if (!rst && avm_write && !avm_waitrequest) begin
      got_addr.push_back(avm_address);
      got_data.push_back(avm_writedata);
      got_be.push_back(avm_byteenable);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    in_valid = 1'b1; in_addr = a; in_data = d; in_byteenable = be;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic expect_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_addr.push_back(a); exp_data.push_back(d); exp_be.push_back(be);
  endtask

  task automatic drain_check(input string tag);
    int n;
    active = 1'b1;
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 300 && !empty; i++) cyc();
    check({tag, "_empty"}, 64'(empty), 64'd1);
    check({tag, "_nbeats"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'(exp_addr[i]));
      check($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(exp_data[i]));
      check($sformatf("%s_be%0d", tag, i), 64'(got_be[i]), 64'(exp_be[i]));
    end
    got_addr.delete(); got_data.delete(); got_be.delete();
    exp_addr.delete(); exp_data.delete(); exp_be.delete();
  endtask

  initial begin
    int          issued;
    logic [31:0] d;

    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; in_byteenable = '0;
    active = 1'b0; avm_waitrequest = 1'b0; probe_addr = '0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    check("rst_empty",    64'(empty),     64'd1);
    check("rst_full",     64'(full),      64'd0);
    check("rst_count",    64'(count),     64'd0);
    check("rst_in_ready", 64'(in_ready),  64'd1);
    check("rst_avm_write",64'(avm_write), 64'd0);
    check("rst_probe_hit",64'(probe_hit), 64'd0);

    // Fill with drain paused, then merge into a pending entry while full
    for (int i = 0; i < 8; i++) begin
      store(32'h100 + 32'(4*i), 32'h1000_0000 + 32'(i), 4'hF);
      expect_beat(32'h100 + 32'(4*i), 32'h1000_0000 + 32'(i), 4'hF);
    end
    check("fill_count", 64'(count), 64'd8);
    check("fill_full",  64'(full),  64'd1);
    in_valid = 1'b1; in_addr = 32'h200; in_data = 32'h5555_5555; in_byteenable = 4'hF;
    #1;
    check("full_new_ready", 64'(in_ready), 64'd0);
    cyc();
    in_valid = 1'b0;
    check("full_new_count", 64'(count), 64'd8);
    in_valid = 1'b1; in_addr = 32'h104; in_data = 32'hDEAD_BEEF; in_byteenable = 4'b0010;
    #1;
    check("full_merge_ready", 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
    check("full_merge_count", 64'(count), 64'd8);
    probe_addr = 32'h104;
    #1;
    check("full_probe_hit",  64'(probe_hit),        64'd1);
    check("full_probe_data", 64'(probe_data),       64'h1000_BE01);
    check("full_probe_be",   64'(probe_byteenable), 64'hF);
    exp_data[1] = 32'h1000_BE01;
    drain_check("fill");

    // Coalesce two stores into one unlocked entry
    active = 1'b0;
    store(32'h40, 32'h1122_3344, 4'b1111);
    store(32'h40, 32'hAABB_CCDD, 4'b0101);
    check("coal_count", 64'(count), 64'd1);
    expect_beat(32'h40, 32'h11BB_33DD, 4'hF);
    drain_check("coal");

    // Store to the locked head allocates a new entry
    active = 1'b1; avm_waitrequest = 1'b1;
    store(32'h80, 32'h0101_0101, 4'hF);
    check("lock_write",  64'(avm_write),   64'd1);
    check("lock_addr",   64'(avm_address), 64'h80);
    in_valid = 1'b1; in_addr = 32'h80; in_data = 32'h0202_0202; in_byteenable = 4'hF;
    #1;
    check("lock_ready", 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
    check("lock_count", 64'(count),         64'd2);
    check("lock_data",  64'(avm_writedata), 64'h0101_0101);
    probe_addr = 32'h80;
    #1;
    check("lock_probe_young", 64'(probe_data), 64'h0202_0202);
    cyc();
    check("lock_hold_addr", 64'(avm_address),   64'h80);
    check("lock_hold_data", 64'(avm_writedata), 64'h0101_0101);
    expect_beat(32'h80, 32'h0101_0101, 4'hF);
    expect_beat(32'h80, 32'h0202_0202, 4'hF);
    drain_check("lock");

    // Dropping active while busy lets the stalled beat finish first
    active = 1'b0; avm_waitrequest = 1'b0;
    store(32'h300, 32'hA0A0_A0A0, 4'hF);
    store(32'h304, 32'hB0B0_B0B0, 4'hF);
    check("drop_idle_gate", 64'(avm_write), 64'd0);
    active = 1'b1; avm_waitrequest = 1'b1;
    #1;
    check("drop_present", 64'(avm_write), 64'd1);
    cyc();
    active = 1'b0;
    #1;
    check("drop_busy_hold", 64'(avm_write),   64'd1);
    check("drop_busy_addr", 64'(avm_address), 64'h300);
    cyc();
    check("drop_busy_hold2", 64'(avm_write), 64'd1);
    avm_waitrequest = 1'b0;
    #1;
    check("drop_accept_cyc", 64'(avm_write), 64'd1);
    cyc();
    check("drop_after_count", 64'(count),     64'd1);
    check("drop_after_write", 64'(avm_write), 64'd0);
    cyc();
    check("drop_after_write2", 64'(avm_write), 64'd0);
    active = 1'b1;
    #1;
    check("drop_resume_write", 64'(avm_write),   64'd1);
    check("drop_resume_addr",  64'(avm_address), 64'h304);
    expect_beat(32'h300, 32'hA0A0_A0A0, 4'hF);
    expect_beat(32'h304, 32'hB0B0_B0B0, 4'hF);
    drain_check("drop");

    // 20 stores against random waitrequest: FIFO order across pointer wrap
    active = 1'b1;
    issued = 0;
    for (int c = 0; c < 400 && issued < 20; c++) begin
      avm_waitrequest = 1'($urandom_range(0, 1));
      d = $urandom;
      in_valid = 1'b1; in_addr = 32'h1000 + 32'(4*issued); in_data = d; in_byteenable = 4'hF;
      #1;
      if (in_ready) begin
        expect_beat(32'h1000 + 32'(4*issued), d, 4'hF);
        issued++;
      end
      cyc();
    end
    in_valid = 1'b0;
    check("wrap_issued", 64'(issued), 64'd20);
    drain_check("wrap");

    // Probe a partially enabled entry and an absent address
    active = 1'b0;
    store(32'h108, 32'hCAFE_F00D, 4'b1100);
    probe_addr = 32'h108;
    #1;
    check("probe_hit",  64'(probe_hit),                      64'd1);
    check("probe_be",   64'(probe_byteenable),               64'b1100);
    check("probe_data", 64'(probe_data & 32'hFFFF_0000),     64'hCAFE_0000);
    probe_addr = 32'h998;
    #1;
    check("probe_miss", 64'(probe_hit), 64'd0);
    expect_beat(32'h108, 32'hCAFE_F00D, 4'b1100);
    drain_check("probe");

    // Reset in the middle of a stalled transfer with five entries queued
    active = 1'b0;
    for (int i = 0; i < 5; i++) store(32'h500 + 32'(4*i), 32'h5000_0000 + 32'(i), 4'hF);
    check("mid_count", 64'(count), 64'd5);
    active = 1'b1; avm_waitrequest = 1'b1;
    cyc();
    check("mid_busy_write", 64'(avm_write), 64'd1);
    rst = 1'b1;
    probe_addr = 32'h500;
    cyc();
    check("mrst_avm_write", 64'(avm_write),        64'd0);
    check("mrst_avm_addr",  64'(avm_address),      64'd0);
    check("mrst_avm_data",  64'(avm_writedata),    64'd0);
    check("mrst_avm_be",    64'(avm_byteenable),   64'd0);
    check("mrst_in_ready",  64'(in_ready),         64'd1);
    check("mrst_empty",     64'(empty),            64'd1);
    check("mrst_full",      64'(full),             64'd0);
    check("mrst_count",     64'(count),            64'd0);
    check("mrst_probe_hit", 64'(probe_hit),        64'd0);
    check("mrst_probe_data",64'(probe_data),       64'd0);
    check("mrst_probe_be",  64'(probe_byteenable), 64'd0);
    rst = 1'b0;
    avm_waitrequest = 1'b0;
    cyc();
    check("post_rst_write", 64'(avm_write), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
